// File: rtl/led_matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_matrix_pkg                                                       |
// | Shared geometry constants and scan state type for the LED scanner.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led_matrix_pkg;

  localparam int NUM_COLS = 16;
  localparam int NUM_ROWS = 4;
  localparam int COL_W    = 4;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/led_frame_banks.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_frame_banks                                                      |
// | Double-buffered 16x4 frame store: writes go to the bank not selected |
// | for display, reads come from the display bank.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_frame_banks
  import led_matrix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_bank_sel,
  input  logic                i_wr_en,
  input  logic [COL_W-1:0]    i_wr_addr,
  input  logic [NUM_ROWS-1:0] i_wr_data,
  input  logic [COL_W-1:0]    i_rd_addr,
  output logic [NUM_ROWS-1:0] o_rd_data
);

  logic [1:0][NUM_COLS-1:0][NUM_ROWS-1:0] r_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (i_wr_en) begin
      r_mem[~i_bank_sel][i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_bank_sel][i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_matrix_scanner                                                   |
// | Captures upstream columns into a double-buffered frame store and     |
// | scans the display bank onto a 16x4 LED matrix with blanking.         |
// | Optional brightness PWM: define LED_SCANNER_PWM_EN.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 64,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                col_valid,
  input  logic [COL_W-1:0]    column_in,
  input  logic [NUM_ROWS-1:0] line_in,
  input  logic [3:0]          brightness,
  output logic [NUM_COLS-1:0] column_sel,
  output logic [NUM_ROWS-1:0] row_drive,
  output logic                frame_done,
  output logic                frame_ready
);

  localparam logic [15:0]      c_blank_last = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0]      c_dwell_last = 16'(DWELL_CYCLES - 1);
  localparam logic [COL_W-1:0] c_last_col   = COL_W'(NUM_COLS - 1);

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  scan_state_t         r_state, w_state_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic [COL_W-1:0]    r_scan_col, w_col_nxt;
  logic [NUM_ROWS-1:0] r_row_latch, w_rd_data, w_row_src, w_row_nxt;
  logic [NUM_COLS-1:0] w_col_sel_nxt;
  logic                r_bank_sel, r_pending;
  logic                w_enter_show, w_wrap, w_wr_last, w_swap, w_row_on;

  // Assertion is immediate; release is delayed two clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  led_frame_banks u_banks (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_bank_sel (r_bank_sel),
    .i_wr_en    (col_valid),
    .i_wr_addr  (column_in),
    .i_wr_data  (line_in),
    .i_rd_addr  (r_scan_col),
    .o_rd_data  (w_rd_data)
  );

  assign w_wr_last = col_valid & (column_in == c_last_col);
  assign w_swap    = w_wrap & (r_pending | w_wr_last);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= BLANK;
      r_cnt      <= '0;
      r_scan_col <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_scan_col <= w_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 16'd1;
    w_col_nxt    = r_scan_col;
    w_enter_show = 1'b0;
    w_wrap       = 1'b0;
    case (r_state)
      BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt  = SHOW;
          w_cnt_nxt    = '0;
          w_enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (r_cnt == c_dwell_last) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_col_nxt   = r_scan_col + 1'b1;
          w_wrap      = (r_scan_col == c_last_col);
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef LED_SCANNER_PWM_EN
  logic [3:0] r_bright, w_bright_src;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)          r_bright <= '0;
    else if (w_enter_show) r_bright <= brightness;
  end

  // Phase is the low nibble of the dwell counter, so duty is brightness/16.
  assign w_bright_src = w_enter_show ? brightness : r_bright;
  assign w_row_on     = (w_cnt_nxt[3:0] < w_bright_src);
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness;
  assign w_row_on            = 1'b1;
`endif

  // Outputs are registered from next-state values so they align with the state.
  assign w_row_src     = w_enter_show ? w_rd_data : r_row_latch;
  assign w_col_sel_nxt = (w_state_nxt == SHOW) ? (NUM_COLS'(1) << w_col_nxt) : '0;
  assign w_row_nxt     = ((w_state_nxt == SHOW) && w_row_on) ? w_row_src : '0;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_row_latch <= '0;
      r_bank_sel  <= 1'b0;
      r_pending   <= 1'b0;
      column_sel  <= '0;
      row_drive   <= '0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      if (w_enter_show) r_row_latch <= w_rd_data;
      column_sel <= w_col_sel_nxt;
      row_drive  <= w_row_nxt;
      frame_done <= w_wrap;
      if (w_swap) begin
        r_bank_sel  <= ~r_bank_sel;
        r_pending   <= 1'b0;
        frame_ready <= 1'b1;
      end else if (w_wr_last) begin
        r_pending <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_matrix_scanner                                                |
// | Randomised bench for led_matrix_scanner with a frame-level model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_led_matrix_scanner;

  localparam int DWELL = 64;
  localparam int BLANK = 4;
  localparam int COLP  = DWELL + BLANK;
  localparam int NCOL  = 16;
  localparam int FRAME = NCOL * COLP;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        col_valid;
  logic [3:0]  column_in;
  logic [3:0]  line_in;
  logic [3:0]  brightness;
  logic [15:0] column_sel;
  logic [3:0]  row_drive;
  logic        frame_done;
  logic        frame_ready;

  always #5 clk = ~clk;

  led_matrix_scanner #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .col_valid  (col_valid),
    .column_in  (column_in),
    .line_in    (line_in),
    .brightness (brightness),
    .column_sel (column_sel),
    .row_drive  (row_drive),
    .frame_done (frame_done),
    .frame_ready(frame_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: p counts cycles from the first blank cycle after reset release.
  int          p;
  logic [3:0]  fw [NCOL];
  logic [3:0]  fd [NCOL];
  logic        pending, ready;
  logic [3:0]  latched, bs;
  logic [15:0] exp_sel;
  logic [3:0]  exp_row;
  logic        exp_done, exp_ready;

  task automatic step();
    int q, c;
    logic [3:0] tmp;
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < NCOL; i++) begin fw[i] = 4'h0; fd[i] = 4'h0; end
      pending = 1'b0; ready = 1'b0; latched = 4'h0; bs = 4'h0; p = -2;
    end else begin
      p++;
      if (p > 0) begin
        if (col_valid) fw[column_in] = line_in;
        if (p % FRAME == 0) begin
          if (pending || (col_valid && column_in == 4'd15)) begin
            for (int i = 0; i < NCOL; i++) begin tmp = fd[i]; fd[i] = fw[i]; fw[i] = tmp; end
            pending = 1'b0;
            ready   = 1'b1;
          end
        end else if (col_valid && column_in == 4'd15) begin
          pending = 1'b1;
        end
      end
    end
    exp_sel   = 16'h0;
    exp_row   = 4'h0;
    exp_done  = reset_n && (p > 0) && (p % FRAME == 0);
    exp_ready = ready;
    if (reset_n && p >= 0) begin
      q = p % COLP;
      c = (p / COLP) % NCOL;
      if (q == BLANK) begin latched = fd[c]; bs = brightness; end
      if (q >= BLANK) begin
        exp_sel = 16'h0001 << c;
        exp_row = latched;
`ifdef LED_SCANNER_PWM_EN
        if (((q - BLANK) % 16) >= int'(bs)) exp_row = 4'h0;
`endif
      end
    end
    #1;
  endtask

  function automatic int cur_col(int pp);
    return (pp < 0) ? -1 : (pp / COLP) % NCOL;
  endfunction

  function automatic int cur_q(int pp);
    return (pp < 0) ? -1 : pp % COLP;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (column_sel !== 16'h0 || row_drive !== 4'h0 || frame_done !== 1'b0 || frame_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset sel=%h row=%h done=%b ready=%b required all zero", column_sel, row_drive, frame_done, frame_ready);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    col_valid = 1'b0;
    for (int i = 0; i < FRAME + 2 * COLP; i++) begin
      brightness = 4'($urandom);
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row || frame_done !== exp_done || frame_ready !== exp_ready) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL idle_scan p=%0d sel=%h exp %h row=%h exp %h done=%b exp %b ready=%b exp %b", p, column_sel, exp_sel, row_drive, exp_row, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
  endtask

  task automatic test_frame_load();
    for (int i = 0; i < 3 * FRAME; i++) begin
      col_valid  = (i < NCOL);
      column_in  = 4'(i);
      line_in    = 4'(i);
      brightness = 4'($urandom);
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row || frame_done !== exp_done || frame_ready !== exp_ready) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL frame_load p=%0d sel=%h exp %h row=%h exp %h done=%b exp %b ready=%b exp %b", p, column_sel, exp_sel, row_drive, exp_row, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
    col_valid = 1'b0;
  endtask

  task automatic test_same_cycle_swap();
    col_valid = 1'b0;
    for (int i = 0; i < FRAME + 2 && (p % FRAME) != FRAME - 1; i++) begin
      brightness = 4'($urandom);
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row || frame_done !== exp_done || frame_ready !== exp_ready) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL same_cycle_wait p=%0d sel=%h exp %h row=%h exp %h", p, column_sel, exp_sel, row_drive, exp_row);
      end
    end
    n_chk++;
    if ((p % FRAME) != FRAME - 1) begin
      n_fail++;
      $display("FAIL same_cycle_align p=%0d required p mod frame %0d", p, FRAME - 1);
    end
    col_valid = 1'b1; column_in = 4'd15; line_in = 4'hA;
    for (int i = 0; i < 2 * FRAME + COLP; i++) begin
      step();
      col_valid  = 1'b0;
      brightness = 4'hF;
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row || frame_done !== exp_done || frame_ready !== exp_ready) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL same_cycle_swap p=%0d sel=%h exp %h row=%h exp %h done=%b exp %b", p, column_sel, exp_sel, row_drive, exp_row, frame_done, exp_done);
      end
`ifndef LED_SCANNER_PWM_EN
      if (i < FRAME && cur_col(p) == 15 && cur_q(p) >= BLANK) begin
        n_chk++;
        if (row_drive !== 4'hA) begin
          n_fail++;
          if (n_fail <= 20) $display("FAIL same_cycle_col15 p=%0d row=%h required a", p, row_drive);
        end
      end
`endif
    end
  endtask

  task automatic test_mid_dwell_write();
    logic [3:0] old_val;
    col_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME && !(cur_col(p) == 3 && cur_q(p) == BLANK + 10); i++) begin
      brightness = 4'hF;
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL mid_dwell_wait p=%0d sel=%h exp %h row=%h exp %h", p, column_sel, exp_sel, row_drive, exp_row);
      end
    end
    old_val = latched;
    col_valid = 1'b1; column_in = 4'd3; line_in = 4'hF;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      col_valid = (i == FRAME);
      column_in = 4'd15;
      line_in   = 4'($urandom);
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row || frame_done !== exp_done || frame_ready !== exp_ready) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL mid_dwell p=%0d sel=%h exp %h row=%h exp %h done=%b exp %b", p, column_sel, exp_sel, row_drive, exp_row, frame_done, exp_done);
      end
`ifndef LED_SCANNER_PWM_EN
      if (cur_col(p) == 3 && cur_q(p) >= BLANK + 10 && i < DWELL - 12) begin
        n_chk++;
        if (row_drive !== old_val) begin
          n_fail++;
          if (n_fail <= 20) $display("FAIL mid_dwell_hold p=%0d row=%h required %h", p, row_drive, old_val);
        end
      end
`endif
    end
    col_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FRAME; i++) begin
      col_valid  = ($urandom_range(0, 2) == 0);
      column_in  = 4'($urandom);
      line_in    = 4'($urandom);
      brightness = 4'($urandom);
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row || frame_done !== exp_done || frame_ready !== exp_ready) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL random p=%0d sel=%h exp %h row=%h exp %h done=%b exp %b ready=%b exp %b", p, column_sel, exp_sel, row_drive, exp_row, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
    col_valid = 1'b0;
  endtask

`ifdef LED_SCANNER_PWM_EN
  task automatic test_pwm();
    logic [3:0] bvals [4];
    int on_cnt;
    int req;
    logic seen_start;
    bvals[0] = 4'd0; bvals[1] = 4'd4; bvals[2] = 4'd15; bvals[3] = 4'd9;
    for (int i = 0; i < 2 * FRAME + NCOL; i++) begin
      col_valid  = (i < NCOL);
      column_in  = 4'(i);
      line_in    = 4'hF;
      brightness = bvals[(cur_col(p + 1) < 0 ? 0 : cur_col(p + 1)) % 4];
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL pwm_load p=%0d sel=%h exp %h row=%h exp %h", p, column_sel, exp_sel, row_drive, exp_row);
      end
    end
    col_valid  = 1'b0;
    on_cnt     = 0;
    seen_start = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      brightness = bvals[cur_col(p + 1) % 4];
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL pwm p=%0d row=%h exp %h", p, row_drive, exp_row);
      end
      if (cur_q(p) == BLANK) begin on_cnt = 0; seen_start = 1'b1; end
      if (cur_q(p) >= BLANK && row_drive === 4'hF) on_cnt++;
      if (cur_q(p) == COLP - 1 && seen_start) begin
        req = int'(bvals[cur_col(p) % 4]) * (DWELL / 16);
        n_chk++;
        if (on_cnt != req) begin
          n_fail++;
          $display("FAIL pwm_duty col=%0d pulses=%0d required %0d", cur_col(p), on_cnt, req);
        end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    col_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME && !(cur_col(p) == 9 && cur_q(p) == BLANK + 20); i++) begin
      brightness = 4'hF;
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL async_wait p=%0d sel=%h exp %h row=%h exp %h", p, column_sel, exp_sel, row_drive, exp_row);
      end
    end
    n_chk++;
    if (column_sel !== 16'h0200) begin
      n_fail++;
      $display("FAIL async_pre sel=%h required 0200", column_sel);
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (column_sel !== 16'h0 || row_drive !== 4'h0 || frame_done !== 1'b0 || frame_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_assert sel=%h row=%h done=%b ready=%b required all zero", column_sel, row_drive, frame_done, frame_ready);
    end
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    for (int i = 0; i < FRAME + 2 * COLP; i++) begin
      brightness = 4'hF;
      step();
      n_chk++;
      if (column_sel !== exp_sel || row_drive !== exp_row || frame_done !== exp_done || frame_ready !== exp_ready) begin
        n_fail++;
        if (n_fail <= 20) $display("FAIL async_restart p=%0d sel=%h exp %h row=%h exp %h done=%b exp %b ready=%b exp %b", p, column_sel, exp_sel, row_drive, exp_row, frame_done, exp_done, frame_ready, exp_ready);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    col_valid  = 1'b0;
    column_in  = 4'h0;
    line_in    = 4'h0;
    brightness = 4'h0;
    p          = -2;
    #2 reset_n = 1'b0;
    test_reset();
    test_idle_scan();
    test_frame_load();
    test_same_cycle_swap();
    test_mid_dwell_write();
    test_random();
`ifdef LED_SCANNER_PWM_EN
    test_pwm();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Downstream consumer of the character multiplexer's column stream. Captures the 4-bit column patterns (`line`) and their column index (`column_to_display_count`, 0–15) into a double-buffered 16×4 frame store. Scans the displayed bank out to a physical 16-column × 4-row LED matrix with fixed dwell time, inter-column blanking and optional brightness PWM. Sits between the character multiplexer and the chip's LED pads.

## Interface

Parameters:
- `DWELL_CYCLES`, default 64: clock cycles each column is driven; legal range 16–65535; must be a multiple of 16 when PWM is compiled in.
- `BLANK_CYCLES`, default 4: all-off cycles between columns; legal range 1–255.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `col_valid`  in  1  `column_in`/`line_in` are valid this cycle.
- `column_in`  in  4  column index from upstream.
- `line_in`  in  4  row pattern for that column; bit 3 is the top row.
- `brightness`  in  4  PWM duty (0–15); ignored unless PWM is compiled in.
- `column_sel`  out  16  one-hot, active-high column enable.
- `row_drive`  out  4  active-high row drive.
- `frame_done`  out  1  one-cycle pulse at scan wrap (column 15 → 0).
- `frame_ready`  out  1  display bank holds a complete upstream frame.

## Operation

Write side:
- When `col_valid`=1, `wbank[column_in]` <= `line_in`.
- A write to column 15 marks the write bank complete and sets `pending_swap`.

Bank swap:
- The swap evaluates only at scan wrap, when `frame_done` fires.
- Swap condition is `pending_swap | (col_valid & column_in==15)`. A column-15 write in the same cycle lands in the outgoing write bank, and that bank then becomes the display bank.
- On swap: toggle the bank select, clear `pending_swap`, and set `frame_ready` (sticky until reset).
- If no frame has completed, no swap occurs and the old display bank repeats.

Scan FSM: states BLANK and SHOW.
- Reset enters BLANK with `scan_col`=0 and `cnt`=0.
- BLANK: `column_sel`=0 and `row_drive`=0. After `BLANK_CYCLES` cycles:
  - go to SHOW;
  - latch `row_latch` <= `dbank[scan_col]`;
  - clear `cnt`;
  - sample `brightness`.
- SHOW: `column_sel` = 1<<`scan_col`; `row_drive` = `row_latch` (PWM-gated if enabled). After `DWELL_CYCLES` cycles:
  - go to BLANK;
  - `scan_col` increments, wrapping 15 → 0;
  - on the wrap, pulse `frame_done` and evaluate the swap.
- Latching at SHOW entry means a swap or write never changes a column mid-dwell.

Widths:
- `cnt` is 16 bits.
- `scan_col` is 4 bits with natural wrap.
- `column_in` out of range cannot occur, because its width equals the column count.

Reset:
- Asserting `reset_n` mid-frame asynchronously forces every output to 0, clears both banks, clears `pending_swap`, and returns the FSM to BLANK at column 0.
- Release is synchronised internally, with two flops.

## Timing

- Output reset values: `column_sel`=0, `row_drive`=0, `frame_done`=0, `frame_ready`=0.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Column period is exactly `BLANK_CYCLES`+`DWELL_CYCLES` cycles; frame period is 16× that.
- `frame_done` is high for exactly the one cycle in which BLANK of column 0 begins.
- Write-to-visible latency: from 1 up to 2 frame periods after the column-15 write.
- Upstream may present `col_valid` every cycle; there is no backpressure.

## Configuration

- `LED_SCANNER_PWM_EN` defined:
  - a 4-bit phase counter (`cnt[3:0]`) runs during SHOW;
  - `row_drive` = `row_latch` when `phase < brightness_sampled`, else 0;
  - `brightness`=0 gives fully dark, 15 gives a 15/16 duty.
- Not defined: `row_drive` = `row_latch` for the whole SHOW; `brightness` is unused, with no PWM logic.

## Structure

- Package `led_matrix_pkg`:
  - `NUM_COLS`=16, `NUM_ROWS`=4, `COL_W`=4;
  - enum `scan_state_t` {BLANK, SHOW}.
- Sub-module `led_frame_banks`: 2×16×4 storage with bank select, one write port and one read port, async-reset clear.
- The scanner FSM, counters and PWM live in the top.

## Test plan

1. Reset release with no writes → `column_sel` walks 0x0001…0x8000, `row_drive`=0 throughout, `frame_done` every 16×68 cycles, `frame_ready`=0.
2. Write columns 0–15 with `line_in`=`column_in` → after the next `frame_done`, `frame_ready`=1 and column k shows `row_drive`=k for 64 cycles, preceded by 4 blank cycles.
3. Column-15 write in the same cycle as `frame_done` → the swap happens at that wrap, and the new value shows at column 15 of the following frame.
4. Rewrite column 3 to 0xF while column 3 is in SHOW → the current dwell keeps the old value; the new frame appears only after a column-15 write and a wrap.
5. `LED_SCANNER_PWM_EN` with `brightness`=4 and pattern 0xF → `row_drive`=0xF for 4 of every 16 SHOW cycles; 0 gives no pulses, 15 gives 15 of 16.
6. Deassert `reset_n` mid-SHOW of column 9 → outputs go to 0 immediately, without a clock; after release, scanning restarts at column 0 with blank banks.
